// File: rtl/ps2_wb8_pkg.sv
// ps2_wb8_pkg: shared definitions for the PS/2 wishbone receiver.
//   - wishbone register addresses
//   - status register bit positions
//   - PS/2 frame geometry
//   - receive FSM state type and frame validity helper
package ps2_wb8_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;

  localparam int ST_NONEMPTY = 0;
  localparam int ST_FULL     = 1;
  localparam int ST_OVF      = 2;
  localparam int ST_ERR      = 3;
  localparam int ST_IRQEN    = 4;

  // start + 8 data + parity + stop
  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS  = FRAME_BITS - 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } rx_state_e;

  // A frame is good when the stop bit is high and data+parity hold an odd
  // number of ones.
  function automatic logic frame_ok(input logic [7:0] data_bits,
                                    input logic       parity_bit,
                                    input logic       stop_bit);
    return stop_bit & (^{data_bits, parity_bit});
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: PS/2 line conditioning and frame deserialiser.
// Ports:
//   I_clk, I_reset     system clock, async active-high reset
//   I_ps2_clk          PS/2 clock line (asynchronous)
//   I_ps2_data         PS/2 data line (asynchronous)
//   O_byte[7:0]        received byte, valid while O_valid is high
//   O_valid            1-cycle pulse for a good frame
//   O_err              1-cycle pulse for a bad start/parity/stop or timeout
module ps2_rx_frame
  import ps2_wb8_pkg::*;
#(
  parameter int CLOCKFREQ  = 25125000,
  parameter int TIMEOUT_US = 200
) (
  input  logic       I_clk,
  input  logic       I_reset,
  input  logic       I_ps2_clk,
  input  logic       I_ps2_data,
  output logic [7:0] O_byte,
  output logic       O_valid,
  output logic       O_err
);

  localparam int TMO_CYCLES = (CLOCKFREQ / 1000000) * TIMEOUT_US;
  localparam int TW         = $clog2(TMO_CYCLES + 1);

  logic            clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic            dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic [3:0]      hist_q, hist_d;
  logic            filt_q, filt_d;
  logic            fall;
  rx_state_e       state_q, state_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic [7:0]      byte_q, byte_d;

  always_comb begin
    clk_s1_d = I_ps2_clk;
    clk_s2_d = clk_s1_q;
    dat_s1_d = I_ps2_data;
    dat_s2_d = dat_s1_q;
    hist_d   = {hist_q[2:0], clk_s2_q};

    // Filtered clock only moves after four identical synchronised samples.
    filt_d = filt_q;
    if (hist_q == 4'b0000)      filt_d = 1'b0;
    else if (hist_q == 4'b1111) filt_d = 1'b1;
    fall = filt_q & ~filt_d;

    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    tcnt_d   = tcnt_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    shift_d  = shift_q;
    par_d    = par_q;
    byte_d   = byte_q;

    if (state_q != S_IDLE) tcnt_d = fall ? '0 : tcnt_q + TW'(1);

    case (state_q)
      S_IDLE: begin
        if (fall) begin
          if (!dat_s2_q) begin
            state_d  = S_DATA;
            bitcnt_d = '0;
            tcnt_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (fall) begin
          shift_d = {dat_s2_q, shift_q[7:1]};
          if (bitcnt_q == 3'(DATA_BITS - 1)) state_d = S_PARITY;
          else bitcnt_d = bitcnt_q + 3'd1;
        end
      end
      S_PARITY: begin
        if (fall) begin
          par_d   = dat_s2_q;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (fall) begin
          state_d = S_IDLE;
          if (frame_ok(shift_q, par_q, dat_s2_q)) begin
            valid_d = 1'b1;
            byte_d  = shift_q;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Device stopped clocking mid-frame: abandon the partial byte.
    if (state_q != S_IDLE && !fall && tcnt_q == TW'(TMO_CYCLES)) begin
      state_d = S_IDLE;
      tcnt_d  = '0;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
      hist_q   <= 4'b1111;
      filt_q   <= 1'b1;
      state_q  <= S_IDLE;
      bitcnt_q <= '0;
      tcnt_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      clk_s1_q <= clk_s1_d;
      clk_s2_q <= clk_s2_d;
      dat_s1_q <= dat_s1_d;
      dat_s2_q <= dat_s2_d;
      hist_q   <= hist_d;
      filt_q   <= filt_d;
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      tcnt_q   <= tcnt_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  // Payload registers carry no reset; they are qualified by the control flops.
  always_ff @(posedge I_clk) begin
    shift_q <= shift_d;
    par_q   <= par_d;
    byte_q  <= byte_d;
  end

  assign O_byte  = byte_q;
  assign O_valid = valid_q;
  assign O_err   = err_q;

endmodule

// File: rtl/ps2_wb8.sv
// ps2_wb8: PS/2 keyboard receiver behind an 8-bit wishbone slave.
// Ports:
//   I_wb_clk, I_reset             system clock, async active-high reset
//   I_wb_adr[1:0], I_wb_dat[7:0]  register select and write data
//   I_wb_stb, I_wb_we             decoded strobe, write enable
//   O_wb_dat[7:0], O_wb_ack       registered read data and single-cycle ack
//   I_ps2_clk, I_ps2_data         asynchronous PS/2 lines
//   O_interrupt                   registered level irq: irq_en & FIFO nonempty
// Registers: 0 data (read pops FIFO), 1 status/control, 2 count, 3 zero.
module ps2_wb8
  import ps2_wb8_pkg::*;
#(
  parameter int CLOCKFREQ     = 25125000,
  parameter int FIFO_ADDRBITS = 3,
  parameter int TIMEOUT_US    = 200
) (
  input  logic       I_wb_clk,
  input  logic       I_reset,
  input  logic [1:0] I_wb_adr,
  input  logic [7:0] I_wb_dat,
  input  logic       I_wb_stb,
  input  logic       I_wb_we,
  output logic [7:0] O_wb_dat,
  output logic       O_wb_ack,
  input  logic       I_ps2_clk,
  input  logic       I_ps2_data,
  output logic       O_interrupt
);

  localparam int AW    = FIFO_ADDRBITS;
  localparam int CW    = FIFO_ADDRBITS + 1;
  localparam int DEPTH = 1 << FIFO_ADDRBITS;

  logic [7:0]    rx_byte;
  logic          rx_valid;
  logic          rx_err;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d, err_q, err_d, irq_en_q, irq_en_d;
  logic          ack_q, ack_d, irq_q, irq_d;
  logic [7:0]    dat_q, dat_d;

  logic          access, rd_acc, wr_acc, nonempty, full, push, pop, ctl_wr;
  logic [7:0]    status;
  logic          unused_wdat;

  ps2_rx_frame #(
    .CLOCKFREQ (CLOCKFREQ),
    .TIMEOUT_US(TIMEOUT_US)
  ) u_rx (
    .I_clk     (I_wb_clk),
    .I_reset   (I_reset),
    .I_ps2_clk (I_ps2_clk),
    .I_ps2_data(I_ps2_data),
    .O_byte    (rx_byte),
    .O_valid   (rx_valid),
    .O_err     (rx_err)
  );

  assign unused_wdat = ^{I_wb_dat[7:5], I_wb_dat[1:0]};

  always_comb begin
    // Side effects only on the first strobe cycle, never on the ack cycle.
    access   = I_wb_stb & ~ack_q;
    rd_acc   = access & ~I_wb_we;
    wr_acc   = access & I_wb_we;
    ctl_wr   = wr_acc && (I_wb_adr == REG_STATUS);
    nonempty = (count_q != '0);
    full     = (count_q == CW'(DEPTH));
    pop      = rd_acc && (I_wb_adr == REG_DATA) && nonempty;
    push     = rx_valid && !full;

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);

    status              = 8'h00;
    status[ST_NONEMPTY] = nonempty;
    status[ST_FULL]     = full;
    status[ST_OVF]      = ovf_q;
    status[ST_ERR]      = err_q;
    status[ST_IRQEN]    = irq_en_q;

    // Software clear first so a same-cycle hardware set wins.
    ovf_d = ovf_q;
    if (ctl_wr && I_wb_dat[ST_OVF]) ovf_d = 1'b0;
    if (rx_valid && full)           ovf_d = 1'b1;

    err_d = err_q;
    if (ctl_wr && I_wb_dat[ST_ERR]) err_d = 1'b0;
    if (rx_err)                     err_d = 1'b1;

    irq_en_d = ctl_wr ? I_wb_dat[ST_IRQEN] : irq_en_q;

    ack_d = I_wb_stb & ~ack_q;

    dat_d = 8'h00;
    if (rd_acc) begin
      case (I_wb_adr)
        REG_DATA:   dat_d = nonempty ? mem_q[rd_ptr_q] : 8'h00;
        REG_STATUS: dat_d = status;
        REG_COUNT:  dat_d = 8'(count_q);
        default:    dat_d = 8'h00;
      endcase
    end

    irq_d = irq_en_q & nonempty;
  end

  always_ff @(posedge I_wb_clk or posedge I_reset) begin
    if (I_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      irq_en_q <= 1'b0;
      ack_q    <= 1'b0;
      dat_q    <= 8'h00;
      irq_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      irq_en_q <= irq_en_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      irq_q    <= irq_d;
    end
  end

  // FIFO storage: contents are meaningful only between the pointers.
  always_ff @(posedge I_wb_clk) begin
    if (push) mem_q[wr_ptr_q] <= rx_byte;
  end

  assign O_wb_dat    = dat_q;
  assign O_wb_ack    = ack_q;
  assign O_interrupt = irq_q;

endmodule

// File: tb/tb_ps2_wb8.sv
`timescale 1ns/1ps
module tb_ps2_wb8;

  // 1 MHz system clock so a 200 us timeout is 200 cycles; 12.5 kHz PS/2 clock.
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] adr;
  logic [7:0] wdat;
  logic       stb, we;
  logic [7:0] odat;
  logic       ack, irq;
  logic       ps2_clk, ps2_data;

  int n_cmp  = 0;
  int n_fail = 0;

  always #500 clk = ~clk;

  ps2_wb8 #(
    .CLOCKFREQ    (1000000),
    .FIFO_ADDRBITS(3),
    .TIMEOUT_US   (200)
  ) dut (
    .I_wb_clk   (clk),
    .I_reset    (rst),
    .I_wb_adr   (adr),
    .I_wb_dat   (wdat),
    .I_wb_stb   (stb),
    .I_wb_we    (we),
    .O_wb_dat   (odat),
    .O_wb_ack   (ack),
    .I_ps2_clk  (ps2_clk),
    .I_ps2_data (ps2_data),
    .O_interrupt(irq)
  );

  // One PS/2 bit: data set mid-high, 40 us low, 40 us high.
  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (20) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (40) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par,
                            input logic stop, input int nbits);
    logic [10:0] f;
    f = {stop, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
    ps2_data = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [7:0] d);
    logic got;
    got = 1'b0;
    d   = 8'hxx;
    @(negedge clk);
    adr = a; we = 1'b0; stb = 1'b1;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk); #1;
      if (ack) begin got = 1'b1; d = odat; end
    end
    stb = 1'b0;
    if (!got) begin
      n_cmp++; n_fail++;
      $display("FAIL wb_read_ack adr=%0d: got no ack, required ack within 4 cycles", a);
    end
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [7:0] d);
    logic got;
    got = 1'b0;
    @(negedge clk);
    adr = a; we = 1'b1; wdat = d; stb = 1'b1;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk); #1;
      if (ack) got = 1'b1;
    end
    stb = 1'b0; we = 1'b0;
    if (!got) begin
      n_cmp++; n_fail++;
      $display("FAIL wb_write_ack adr=%0d: got no ack, required ack within 4 cycles", a);
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    stb = 1'b0; we = 1'b0; adr = 2'd0; wdat = 8'h00;
    repeat (3) @(negedge clk);
    n_cmp++; if (ack !== 1'b0)   begin n_fail++; $display("FAIL reset_ack got=%b want=0", ack); end
    n_cmp++; if (odat !== 8'h00) begin n_fail++; $display("FAIL reset_dat got=%h want=00", odat); end
    n_cmp++; if (irq !== 1'b0)   begin n_fail++; $display("FAIL reset_irq got=%b want=0", irq); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    wb_read(2'd1, d);
    n_cmp++; if (d !== 8'h00) begin n_fail++; $display("FAIL reset_status got=%h want=00", d); end
    wb_read(2'd2, d);
    n_cmp++; if (d !== 8'h00) begin n_fail++; $display("FAIL reset_count got=%h want=00", d); end
  endtask

  task automatic test_single_byte();
    logic [7:0] d;
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    wb_read(2'd1, d);
    n_cmp++; if (d !== 8'h01) begin n_fail++; $display("FAIL single_status got=%h want=01", d); end
    wb_read(2'd2, d);
    n_cmp++; if (d !== 8'h01) begin n_fail++; $display("FAIL single_count got=%h want=01", d); end
    wb_read(2'd0, d);
    n_cmp++; if (d !== 8'h1C) begin n_fail++; $display("FAIL single_data got=%h want=1c", d); end
    wb_read(2'd1, d);
    n_cmp++; if (d !== 8'h00) begin n_fail++; $display("FAIL single_status_after got=%h want=00", d); end
    wb_read(2'd3, d);
    n_cmp++; if (d !== 8'h00) begin n_fail++; $display("FAIL reg3 got=%h want=00", d); end
  endtask

  task automatic test_parity_err();
    logic [7:0] d;
    send_frame(8'h1C, 1'b1, 1'b1, 11);
    wb_read(2'd1, d);
    n_cmp++; if (d !== 8'h08) begin n_fail++; $display("FAIL parity_status got=%h want=08", d); end
    wb_read(2'd2, d);
    n_cmp++; if (d !== 8'h00) begin n_fail++; $display("FAIL parity_count got=%h want=00", d); end
    wb_write(2'd1, 8'h08);
    wb_read(2'd1, d);
    n_cmp++; if (d !== 8'h00) begin n_fail++; $display("FAIL parity_clear got=%h want=00", d); end
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    logic       pars [9];
    pars = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 9; i++) send_frame(8'(i + 1), pars[i], 1'b1, 11);
    wb_read(2'd2, d);
    n_cmp++; if (d !== 8'h08) begin n_fail++; $display("FAIL ovf_count got=%h want=08", d); end
    wb_read(2'd1, d);
    n_cmp++; if (d !== 8'h07) begin n_fail++; $display("FAIL ovf_status got=%h want=07", d); end
    for (int i = 1; i <= 8; i++) begin
      wb_read(2'd0, d);
      n_cmp++; if (d !== 8'(i)) begin n_fail++; $display("FAIL ovf_drain%0d got=%h want=%h", i, d, 8'(i)); end
    end
    wb_read(2'd0, d);
    n_cmp++; if (d !== 8'h00) begin n_fail++; $display("FAIL ovf_empty_read got=%h want=00", d); end
    wb_read(2'd1, d);
    n_cmp++; if (d !== 8'h04) begin n_fail++; $display("FAIL ovf_sticky got=%h want=04", d); end
    wb_write(2'd1, 8'h04);
    wb_read(2'd1, d);
    n_cmp++; if (d !== 8'h00) begin n_fail++; $display("FAIL ovf_clear got=%h want=00", d); end
  endtask

  task automatic test_timeout();
    logic [7:0] d;
    send_frame(8'hA5, 1'b1, 1'b1, 5);
    repeat (300) @(negedge clk);
    send_frame(8'h5A, 1'b1, 1'b1, 11);
    wb_read(2'd1, d);
    n_cmp++; if (d !== 8'h09) begin n_fail++; $display("FAIL tmo_status got=%h want=09", d); end
    wb_read(2'd2, d);
    n_cmp++; if (d !== 8'h01) begin n_fail++; $display("FAIL tmo_count got=%h want=01", d); end
    wb_read(2'd0, d);
    n_cmp++; if (d !== 8'h5A) begin n_fail++; $display("FAIL tmo_data got=%h want=5a", d); end
    wb_write(2'd1, 8'h08);
  endtask

  task automatic test_irq_back_to_back();
    logic [7:0]  d;
    logic [10:0] f;
    wb_write(2'd1, 8'h10);
    repeat (5) @(negedge clk);
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_empty got=%b want=0", irq); end
    wb_read(2'd1, d);
    n_cmp++; if (d !== 8'h10) begin n_fail++; $display("FAIL irq_en_status got=%h want=10", d); end
    // 0xF0: all but the stop bit, then time the stop-bit fall by hand.
    // Fall -> sync(2) -> filter(4) -> rx valid -> FIFO count -> irq.
    f = {1'b1, 1'b1, 8'hF0, 1'b0};
    for (int i = 0; i < 10; i++) ps2_bit(f[i]);
    ps2_data = 1'b1;
    repeat (20) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (8) @(posedge clk); #1;
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_before_push got=%b want=0", irq); end
    @(posedge clk); #1;
    n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_after_push got=%b want=1", irq); end
    repeat (30) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (20) @(negedge clk);
    // 0x12: pop 0xF0 in the very cycle the new byte is pushed.
    f = {1'b1, 1'b1, 8'h12, 1'b0};
    for (int i = 0; i < 10; i++) ps2_bit(f[i]);
    ps2_data = 1'b1;
    repeat (20) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    adr = 2'd0; we = 1'b0; stb = 1'b1;
    @(posedge clk); #1;
    stb = 1'b0;
    n_cmp++; if (ack !== 1'b1)   begin n_fail++; $display("FAIL b2b_ack got=%b want=1", ack); end
    n_cmp++; if (odat !== 8'hF0) begin n_fail++; $display("FAIL b2b_data got=%h want=f0", odat); end
    repeat (30) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (20) @(negedge clk);
    wb_read(2'd2, d);
    n_cmp++; if (d !== 8'h01) begin n_fail++; $display("FAIL b2b_count got=%h want=01", d); end
    wb_read(2'd0, d);
    n_cmp++; if (d !== 8'h12) begin n_fail++; $display("FAIL b2b_second got=%h want=12", d); end
    repeat (3) @(negedge clk);
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_drained got=%b want=0", irq); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    send_frame(8'h33, 1'b1, 1'b1, 11);
    n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL pre_reset_irq got=%b want=1", irq); end
    send_frame(8'h77, 1'b0, 1'b1, 5);
    @(negedge clk);
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    #10;
    n_cmp++; if (irq !== 1'b0)   begin n_fail++; $display("FAIL midrst_irq got=%b want=0", irq); end
    n_cmp++; if (ack !== 1'b0)   begin n_fail++; $display("FAIL midrst_ack got=%b want=0", ack); end
    n_cmp++; if (odat !== 8'h00) begin n_fail++; $display("FAIL midrst_dat got=%h want=00", odat); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    send_frame(8'h29, 1'b0, 1'b1, 11);
    wb_read(2'd1, d);
    n_cmp++; if (d !== 8'h01) begin n_fail++; $display("FAIL postrst_status got=%h want=01", d); end
    wb_read(2'd2, d);
    n_cmp++; if (d !== 8'h01) begin n_fail++; $display("FAIL postrst_count got=%h want=01", d); end
    wb_read(2'd0, d);
    n_cmp++; if (d !== 8'h29) begin n_fail++; $display("FAIL postrst_data got=%h want=29", d); end
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL postrst_irq got=%b want=0", irq); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_parity_err();
    test_overflow();
    test_timeout();
    test_irq_back_to_back();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100_000_000;
    $display("FAIL watchdog: simulation did not finish within 100000 cycles");
    $fatal(1);
  end

endmodule
